regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port among NUM_REQ writeback sources (ALU result, load data, ...).

---
 rtl/regfile_pkg.sv | 15 +
 rtl/rr_priority_picker.sv | 31 +++
 rtl/regfile_write_arbiter.sv | 96 +++++++++
 tb/tb_regfile_write_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, the hard-wired zero register index and the round-robin helper.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 64;

  // Writes to this index are accepted but never reach the file.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

  // Index that follows idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first valid index at or after ptr wins.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_grant
);

  logic [PTR_W-1:0] cand;

  // Walk ptr, ptr+1, ... (mod NUM_REQ) and keep only the first valid hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!any_grant && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any_grant   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port with a one-cycle write stage.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      pend_valid,
  output logic [ADDR_W-1:0]         pend_addr
);

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("regfile_write_arbiter: NUM_REQ must be within 2..4");
  end

  localparam int unsigned PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               any_grant;
  logic               handshake;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Grants are suppressed while frozen or in reset; picker output only reflects valid bits.
  assign handshake = any_grant & ~hold & ~reset;
  assign req_ready = handshake ? grant : '0;
  assign sel_addr  = req_addr[32'(grant_idx) * ADDR_W +: ADDR_W];
  assign sel_data  = req_data[32'(grant_idx) * DATA_W +: DATA_W];

  // Next priority pointer: one past the winner, unchanged when nobody is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (handshake) begin
      ptr_d = PTR_W'(rr_next(32'(grant_idx), NUM_REQ));
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Write-stage enable and index; zero-register writes are swallowed here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else if (handshake) begin
      wr_en   <= (sel_addr != ADDR_W'(ZERO_REG));
      wr_addr <= sel_addr;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Write-stage data, held when no handshake occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_data <= '0;
    end else if (handshake) begin
      wr_data <= sel_data;
    end
  end

  assign pend_valid = wr_en;
  assign pend_addr  = wr_addr;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with NUM_REQ=2 and NUM_REQ=4 instances.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic hold2, hold4;

  logic [1:0]   valid2, ready2;
  logic [9:0]   addr2;
  logic [127:0] data2;
  logic         wr_en2, pend_valid2;
  logic [4:0]   wr_addr2, pend_addr2;
  logic [63:0]  wr_data2;

  logic [3:0]   valid4, ready4;
  logic [19:0]  addr4;
  logic [255:0] data4;
  logic         wr_en4, pend_valid4;
  logic [4:0]   wr_addr4, pend_addr4;
  logic [63:0]  wr_data4;

  // Per-instance requester addresses/data: [instance][requester].
  logic [4:0]  a  [2][4];
  logic [63:0] dv [2][4];

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [4:0]  m_addr[2];
  logic [63:0] m_data[2];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign addr2 = {a[0][1], a[0][0]};
  assign data2 = {dv[0][1], dv[0][0]};
  assign addr4 = {a[1][3], a[1][2], a[1][1], a[1][0]};
  assign data4 = {dv[1][3], dv[1][2], dv[1][1], dv[1][0]};

  regfile_write_arbiter #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(64)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold2),
    .req_valid  (valid2),
    .req_addr   (addr2),
    .req_data   (data2),
    .req_ready  (ready2),
    .wr_en      (wr_en2),
    .wr_addr    (wr_addr2),
    .wr_data    (wr_data2),
    .pend_valid (pend_valid2),
    .pend_addr  (pend_addr2)
  );

  regfile_write_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(64)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold4),
    .req_valid  (valid4),
    .req_addr   (addr4),
    .req_data   (data4),
    .req_ready  (ready4),
    .wr_en      (wr_en4),
    .wr_addr    (wr_addr4),
    .wr_data    (wr_data4),
    .pend_valid (pend_valid4),
    .pend_addr  (pend_addr4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: drive, check grant, push expected write, clock, pop and check write.
  task automatic step(input int d, input logic [3:0] valid, input logic h,
                      input logic [3:0] exp_ready, input string tag);
    wr_t         e, got;
    logic [3:0]  rdy;
    logic        o_en, o_pv;
    logic [4:0]  o_a, o_pa;
    logic [63:0] o_d;
    if (d == 0) begin
      valid2 = valid[1:0];
      hold2  = h;
    end else begin
      valid4 = valid;
      hold4  = h;
    end
    #1;
    rdy = (d == 0) ? {2'b00, ready2} : ready4;
    chk($sformatf("%s ready", tag), {60'd0, rdy}, {60'd0, exp_ready});
    e.en   = 1'b0;
    e.addr = m_addr[d];
    e.data = m_data[d];
    for (int i = 0; i < 4; i++) begin
      if (exp_ready[i]) begin
        e.addr = a[d][i];
        e.data = dv[d][i];
        e.en   = (a[d][i] != 5'd31);
      end
    end
    m_addr[d] = e.addr;
    m_data[d] = e.data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (d == 0) begin
      o_en = wr_en2; o_a = wr_addr2; o_d = wr_data2; o_pv = pend_valid2; o_pa = pend_addr2;
    end else begin
      o_en = wr_en4; o_a = wr_addr4; o_d = wr_data4; o_pv = pend_valid4; o_pa = pend_addr4;
    end
    got = sb.pop_front();
    chk($sformatf("%s wr_en", tag), {63'd0, o_en}, {63'd0, got.en});
    chk($sformatf("%s wr_addr", tag), {59'd0, o_a}, {59'd0, got.addr});
    chk($sformatf("%s wr_data", tag), o_d, got.data);
    chk($sformatf("%s pend_valid", tag), {63'd0, o_pv}, {63'd0, got.en});
    chk($sformatf("%s pend_addr", tag), {59'd0, o_pa}, {59'd0, got.addr});
  endtask

  initial begin
    reset  = 1'b1;
    hold2  = 1'b0;
    hold4  = 1'b0;
    valid2 = 2'b11;
    valid4 = 4'b0000;
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = 5'd0;
      m_data[d] = 64'd0;
      for (int i = 0; i < 4; i++) begin
        a[d][i]  = 5'd0;
        dv[d][i] = 64'd0;
      end
    end
    a[0][0]  = 5'd3;
    a[0][1]  = 5'd7;
    dv[0][0] = 64'hA0A0_0000_0000_0003;
    dv[0][1] = 64'hB1B1_0000_0000_0007;

    // Reset with both requesters valid.
    #1;
    chk("reset ready", {62'd0, ready2}, 64'd0);
    chk("reset wr_en", {63'd0, wr_en2}, 64'd0);
    chk("reset wr_addr", {59'd0, wr_addr2}, 64'd0);
    chk("reset wr_data", wr_data2, 64'd0);
    chk("reset pend_valid", {63'd0, pend_valid2}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First grant goes to req0, then strict alternation.
    step(0, 4'b0011, 1'b0, 4'b0001, "t1 first");
    step(0, 4'b0011, 1'b0, 4'b0010, "t2 rr1");
    step(0, 4'b0011, 1'b0, 4'b0001, "t2 rr2");
    step(0, 4'b0011, 1'b0, 4'b0010, "t2 rr3");
    step(0, 4'b0011, 1'b0, 4'b0001, "t2 rr4");
    step(0, 4'b0011, 1'b0, 4'b0010, "t2 rr5");

    // Hold freezes grants and pointer; the ptr winner (req0) comes first afterwards.
    step(0, 4'b0011, 1'b1, 4'b0000, "t4 hold1");
    step(0, 4'b0011, 1'b1, 4'b0000, "t4 hold2");
    step(0, 4'b0011, 1'b1, 4'b0000, "t4 hold3");
    step(0, 4'b0011, 1'b0, 4'b0001, "t4 release");

    // Zero-register write accepted but dropped; pointer still advances.
    a[0][1]  = 5'd31;
    dv[0][1] = 64'hDEAD;
    step(0, 4'b0010, 1'b0, 4'b0010, "t3 zero_reg");
    step(0, 4'b0011, 1'b0, 4'b0001, "t3 ptr0");

    // Reset lands mid-cycle during a handshake and with a write in flight.
    a[0][0]  = 5'd5;
    dv[0][0] = 64'h1234;
    valid2   = 2'b01;
    #1;
    chk("t5 pre ready", {62'd0, ready2}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5 rst ready", {62'd0, ready2}, 64'd0);
    chk("t5 rst wr_en async", {63'd0, wr_en2}, 64'd0);
    chk("t5 rst wr_addr async", {59'd0, wr_addr2}, 64'd0);
    @(posedge clk);
    #1;
    chk("t5 no write wr_en", {63'd0, wr_en2}, 64'd0);
    chk("t5 no write wr_addr", {59'd0, wr_addr2}, 64'd0);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = 5'd0;
      m_data[d] = 64'd0;
    end
    a[0][1] = 5'd7;
    step(0, 4'b0011, 1'b0, 4'b0001, "t5 rearb ptr0");
    valid2 = 2'b00;

    // Four requesters, sparse valid pattern starting from ptr=2.
    for (int i = 0; i < 4; i++) begin
      a[1][i]  = 5'(10 + i);
      dv[1][i] = 64'h4000 + 64'(i);
    end
    step(1, 4'b0010, 1'b0, 4'b0010, "t6 set ptr2");
    step(1, 4'b1010, 1'b0, 4'b1000, "t6 g3");
    step(1, 4'b1010, 1'b0, 4'b0010, "t6 g1");
    step(1, 4'b1010, 1'b0, 4'b1000, "t6 g3b");
    step(1, 4'b0000, 1'b0, 4'b0000, "t6 idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
